// File: rtl/piano_key_encoder.sv
// Eight-key piano front end: synchronise, debounce, priority-encode and track note on/off.
// Define NOTE_LATCH_EN to hold the last note after all keys are released.
module piano_key_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned CNT_W           = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] keys,
  output logic [3:0] note,
  output logic       note_start,
  output logic       note_end,
  output logic [7:0] keys_db
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       NoteNone = 4'd8;

`ifdef NOTE_LATCH_EN
  typedef enum logic [1:0] {StIdle, StPlay, StLatched} state_e;
`else
  typedef enum logic [0:0] {StIdle, StPlay} state_e;
`endif

  logic [7:0]       r_sync1;
  logic [7:0]       r_sync2;
  logic [7:0]       r_keys_db;
  logic [CNT_W-1:0] r_cnt [8];

  state_e     r_state;
  state_e     w_state_d;
  logic [3:0] r_note;
  logic [3:0] w_note_d;
  logic       r_start;
  logic       w_start_d;
  logic       r_end;
  logic       w_end_d;
  logic [3:0] w_sel;

  // Counter toggles the level on its last differing cycle, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_keys_db <= '0;
      for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= keys;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 8; i++) begin
        if (r_sync2[i] == r_keys_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CntLast) begin
          r_cnt[i]     <= '0;
          r_keys_db[i] <= ~r_keys_db[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sel = NoteNone;
    for (int i = 7; i >= 0; i--) begin
      if (r_keys_db[i]) w_sel = 4'(i);
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_note_d  = r_note;
    w_start_d = 1'b0;
    w_end_d   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_sel != NoteNone) begin
          w_state_d = StPlay;
          w_note_d  = w_sel;
          w_start_d = 1'b1;
        end
      end
      StPlay: begin
        if (w_sel == NoteNone) begin
`ifdef NOTE_LATCH_EN
          w_state_d = StLatched;
`else
          w_state_d = StIdle;
          w_note_d  = NoteNone;
          w_end_d   = 1'b1;
`endif
        end else if (w_sel != r_note) begin
          w_note_d  = w_sel;
          w_start_d = 1'b1;
        end
      end
`ifdef NOTE_LATCH_EN
      StLatched: begin
        if (w_sel != NoteNone) begin
          w_state_d = StPlay;
          w_note_d  = w_sel;
          w_start_d = 1'b1;
        end
      end
`endif
      default: begin
        w_state_d = StIdle;
        w_note_d  = NoteNone;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_note  <= NoteNone;
      r_start <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_note  <= w_note_d;
      r_start <= w_start_d;
      r_end   <= w_end_d;
    end
  end

  assign note       = r_note;
  assign note_start = r_start;
  assign note_end   = r_end;
  assign keys_db    = r_keys_db;

endmodule

// File: tb/tb_piano_key_encoder.sv
// Scoreboard bench for piano_key_encoder with DEBOUNCE_CYCLES=4: expected note events
// are queued with their due cycle when keys change and matched against DUT pulses.
module tb_piano_key_encoder;

  localparam int Lat = 7;

  typedef struct {
    int         cyc;
    logic [3:0] note;
    logic       s;
    logic       e;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] keys = '0;
  logic [3:0] note;
  logic       note_start;
  logic       note_end;
  logic [7:0] keys_db;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  ev_t        q[$];
  logic [3:0] last_note = 4'd8;

  piano_key_encoder #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .keys      (keys),
    .note      (note),
    .note_start(note_start),
    .note_end  (note_end),
    .keys_db   (keys_db)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_keys(input logic [7:0] k);
    @(negedge clk);
    keys = k;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_start(input logic [3:0] n);
    q.push_back('{cyc: cyc + Lat, note: n, s: 1'b1, e: 1'b0});
    last_note = n;
  endtask

  // Releasing everything ends the note unless the latch option holds it.
  task automatic exp_release();
`ifndef NOTE_LATCH_EN
    q.push_back('{cyc: cyc + Lat, note: 4'd8, s: 1'b0, e: 1'b1});
    last_note = 4'd8;
`endif
  endtask

  always @(negedge clk) begin
    if (note_start || note_end) begin
      ev_t ev;
      check_eq("start_and_end", 32'(note_start & note_end), 32'd0);
      if (q.size() == 0) begin
        check_eq("unexpected_pulse", 32'(note), 32'd15);
      end else begin
        ev = q.pop_front();
        check_eq("event_cycle", 32'(cyc), 32'(ev.cyc));
        check_eq("event_note", 32'(note), 32'(ev.note));
        check_eq("event_start", 32'(note_start), 32'(ev.s));
        check_eq("event_end", 32'(note_end), 32'(ev.e));
      end
    end
  end

  initial begin
    wait_cycles(3);
    check_eq("rst_note", 32'(note), 32'd8);
    check_eq("rst_keys_db", 32'(keys_db), 32'd0);
    check_eq("rst_pulses", 32'({note_start, note_end}), 32'd0);
    rst = 1'b0;
    wait_cycles(2);

    // Single key press and release
    set_keys(8'h04); exp_start(4'd2);
    wait_cycles(12);
    check_eq("hold_note", 32'(note), 32'd2);
    check_eq("hold_keys_db", 32'(keys_db), 32'h04);
    set_keys(8'h00); exp_release();
    wait_cycles(12);
    check_eq("rel_keys_db", 32'(keys_db), 32'd0);
    check_eq("rel_note", 32'(note), 32'(last_note));

    // Three-cycle glitch must be rejected
    set_keys(8'h20);
    wait_cycles(2);
    set_keys(8'h00);
    wait_cycles(15);
    check_eq("glitch_keys_db", 32'(keys_db), 32'd0);
    check_eq("glitch_note", 32'(note), 32'(last_note));

    // Retrigger on higher priority, back on release
    set_keys(8'h40); exp_start(4'd6);
    wait_cycles(12);
    set_keys(8'h42); exp_start(4'd1);
    wait_cycles(12);
    check_eq("retrig_note", 32'(note), 32'd1);
    set_keys(8'h40); exp_start(4'd6);
    wait_cycles(12);
    check_eq("back_note", 32'(note), 32'd6);
    set_keys(8'h00); exp_release();
    wait_cycles(12);

    // Simultaneous keys give one start for the lowest index
    set_keys(8'h81); exp_start(4'd0);
    wait_cycles(12);
    check_eq("simul_keys_db", 32'(keys_db), 32'h81);
    check_eq("simul_note", 32'(note), 32'd0);
    set_keys(8'h00); exp_release();
    wait_cycles(12);

    // Lower-priority activity under a held key is silent
    set_keys(8'h01); exp_start(4'd0);
    wait_cycles(12);
    set_keys(8'h09);
    wait_cycles(12);
    set_keys(8'h01);
    wait_cycles(12);
    check_eq("lowpri_note", 32'(note), 32'd0);
    set_keys(8'h00); exp_release();
    wait_cycles(12);

    // Reset mid-note, keys still held
    set_keys(8'h08); exp_start(4'd3);
    wait_cycles(12);
    check_eq("pre_rst_note", 32'(note), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_note", 32'(note), 32'd8);
    check_eq("mid_rst_pulses", 32'({note_start, note_end}), 32'd0);
    check_eq("mid_rst_keys_db", 32'(keys_db), 32'd0);
    rst = 1'b0;
    last_note = 4'd8;
    exp_start(4'd3);
    wait_cycles(12);
    check_eq("post_rst_note", 32'(note), 32'd3);
    set_keys(8'h00); exp_release();
    wait_cycles(12);

    // Press, release, press again on the same key
    set_keys(8'h10); exp_start(4'd4);
    wait_cycles(12);
    set_keys(8'h00); exp_release();
    wait_cycles(12);
    check_eq("repress_idle_note", 32'(note), 32'(last_note));
    set_keys(8'h10); exp_start(4'd4);
    wait_cycles(12);
    set_keys(8'h00); exp_release();
    wait_cycles(20);

    check_eq("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piano_key_encoder.md
PIANO_KEY_ENCODER -- requirements
Module: piano_key_encoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 100000, the consecutive stable cycles required to accept a key change (range 2..2^CNT_W-1).
REQ-002 The block SHALL have parameter CNT_W, default 17, the debounce counter width.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-005 The block SHALL have port keys, input, 8, raw asynchronous active-high buttons: keys[0]=C5, [1]=B, [2]=A, [3]=G, [4]=F, [5]=E, [6]=D, [7]=C4.
REQ-006 The block SHALL have port note, output, 4, the current note code: 0=C5, 1=B, 2=A, 3=G, 4=F, 5=E, 6=D, 7=C4, 8=none; this is the same bus the segment display consumes.
REQ-007 The block SHALL have port note_start, output, 1, a one-cycle pulse on the cycle note takes a new value 0..7.
REQ-008 The block SHALL have port note_end, output, 1, a one-cycle pulse on the cycle note returns to 8.
REQ-009 The block SHALL have port keys_db, output, 8, the debounced key levels.

Function
REQ-010 Each keys bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each key SHALL have a CNT_W-bit counter.
- Counter clears on any cycle where the synchronized bit equals keys_db[i].
- Counter increments while the two differ.
- keys_db[i] toggles, and the counter clears, on the DEBOUNCE_CYCLES-th consecutive differing cycle.
REQ-012 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave keys_db unchanged; counters SHALL NOT wrap.
REQ-013 Priority select SHALL choose the lowest set index of keys_db, giving code 0..7; with no bit set it SHALL give 8.
REQ-014 note SHALL be registered, updating one cycle after keys_db changes.
- Total latency from a clean keys edge to note is 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-015 The FSM SHALL have states IDLE (note=8) and PLAY (note=0..7), plus LATCHED when configured (REQ-024).
REQ-016 FSM transitions SHALL be:
- IDLE->PLAY when the selected code is not 8; note_start pulses.
- PLAY->IDLE when the selected code becomes 8; note_end pulses.
- PLAY->PLAY with a new code when the selected code changes to another value 0..7; note_start pulses again (retrigger), no note_end.
REQ-017 Simultaneous acceptance of several keys in one cycle SHALL produce exactly one note_start, for the lowest index.
REQ-018 Pressing or releasing a lower-priority key while a higher-priority key is held SHALL produce no pulse and no note change.
REQ-019 Releasing the playing key while a lower-priority key is held SHALL switch note to that key and pulse note_start.
REQ-020 note_start and note_end SHALL never both be asserted in the same cycle.

Reset
REQ-021 While rst is high at a clk edge, all of the following SHALL be cleared:
- synchronizers, counters and keys_db to 0;
- FSM to IDLE, note to 8;
- note_start and note_end to 0.
REQ-022 rst asserted mid-note SHALL force note to 8 on the next edge without a note_end pulse.
REQ-023 After rst deasserts, keys already held SHALL be accepted only after the full debounce latency.

Configuration
REQ-024 With macro NOTE_LATCH_EN defined, releasing all keys in PLAY SHALL move the FSM to LATCHED.
- note holds the last code and no note_end pulses.
- A new press leaves LATCHED for PLAY with note_start, even if the code is unchanged.
- Only rst returns the FSM to IDLE.
REQ-025 With NOTE_LATCH_EN undefined, the LATCHED state SHALL NOT exist and the behaviour SHALL be as REQ-016.

Verification (DEBOUNCE_CYCLES=4, NOTE_LATCH_EN undefined unless stated)
REQ-026 Hold keys=0x04 -> note=2 with a note_start pulse exactly 7 cycles after the edge; release -> note=8 with a note_end pulse 7 cycles after release.
REQ-027 3-cycle pulse on keys[5] -> keys_db, note and pulses unchanged.
REQ-028 Hold keys[6], then add keys[1] -> note 6 then 1, with two note_start pulses and no note_end; release keys[1] -> note=6 with a third note_start.
REQ-029 keys 0x81 applied in the same cycle -> a single note_start with note=0.
REQ-030 rst pulse while note=3 -> note=8 on the next cycle, no note_end; keys still held -> note=3 again 7 cycles after rst falls.
REQ-031 NOTE_LATCH_EN defined: press then release keys[4] -> note stays 4 with no note_end; press keys[4] again -> note_start pulse.
